// File: rtl/bittiming_ctrl.sv
// CAN bit-timing sequencer: drives the tq counter controls and splits each bit into SYNC/SEG1/SEG2.
// Optional macro TRIPLE_SAMPLE_EN adds the smp_pre strobe and raises the tseg1 floor to 3.
module bittiming_ctrl #(
    parameter int CW = 4,
    parameter int SW = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          prescale_en,
    input  logic [CW-1:0] counto,
    input  logic [3:0]    tseg1,
    input  logic [2:0]    tseg2,
    input  logic [SW-1:0] sjw,
    input  logic          rx_edge,
    input  logic          hard_sync_en,
    output logic          increment,
    output logic          setctzero,
    output logic          setctotwo,
    output logic          sample_pt,
    output logic          bit_start,
`ifdef TRIPLE_SAMPLE_EN
    output logic          smp_pre,
`endif
    output logic [1:0]    seg
);

    typedef enum logic [1:0] {
        SEG_IDLE = 2'd0,
        SEG_SYNC = 2'd1,
        SEG_TS1  = 2'd2,
        SEG_TS2  = 2'd3
    } seg_e;

    // Internal arithmetic width: holds tseg1 + sjw and counto + sjw without overflow.
    localparam int            EW      = ((CW > 5) ? CW : 5) + 1;
    localparam logic [EW-1:0] CNT_MAX = EW'((1 << CW) - 1);
`ifdef TRIPLE_SAMPLE_EN
    localparam logic [3:0]    TSEG1_MIN = 4'd3;
`else
    localparam logic [3:0]    TSEG1_MIN = 4'd2;
`endif

    seg_e          seg_q, seg_d;
    logic [SW-1:0] ext_q, ext_d;
    logic [SW-1:0] shr_q, shr_d;
    logic          done_q, done_d;

    logic [3:0]    tseg1_eff;
    logic [2:0]    tseg2_eff;
    logic [EW-1:0] cnt_w, sjw_w, t1_w, t2_w;
    logic [SW-1:0] ext_late, ext_use, shr_use;
    logic [EW-1:0] end1_w, end2_w;
    logic          tick, hard_hit, resync_hit, early_as_sync;

    always_comb begin
        tseg1_eff = (tseg1 < TSEG1_MIN) ? TSEG1_MIN : tseg1;
        tseg2_eff = (tseg2 == 3'd0) ? 3'd1 : tseg2;
        cnt_w     = EW'(counto);
        sjw_w     = EW'(sjw);
        t1_w      = EW'(tseg1_eff);
        t2_w      = EW'(tseg2_eff);

        tick       = prescale_en & ~reset;
        hard_hit   = tick & rx_edge & hard_sync_en;
        resync_hit = tick & rx_edge & ~hard_sync_en & ~done_q &
                     ((seg_q == SEG_TS1) || (seg_q == SEG_TS2));

        // A resync edge takes effect on the segment end within the same tick.
        ext_late = (cnt_w < sjw_w) ? SW'(counto) : sjw;
        ext_use  = resync_hit ? ext_late : ext_q;
        shr_use  = resync_hit ? sjw : shr_q;

        end1_w = t1_w + EW'(ext_use);
        if (end1_w > CNT_MAX) begin
            end1_w = CNT_MAX;
        end
        end2_w = ((EW'(shr_use) + EW'(1)) >= t2_w) ? '0 : (t2_w - EW'(shr_use) - EW'(1));

        // Early edge close enough to the bit end: restart the bit as if this tq were SYNC.
        early_as_sync = resync_hit && (t2_w <= (cnt_w + sjw_w));
    end

    always_comb begin
        seg_d     = seg_q;
        ext_d     = ext_q;
        shr_d     = shr_q;
        done_d    = done_q;
        increment = 1'b0;
        setctzero = 1'b0;
        setctotwo = 1'b0;
        sample_pt = 1'b0;
        bit_start = 1'b0;
`ifdef TRIPLE_SAMPLE_EN
        smp_pre   = 1'b0;
`endif
        if (hard_hit) begin
            setctotwo = 1'b1;
            seg_d     = SEG_TS1;
            ext_d     = '0;
            shr_d     = '0;
        end else if (tick) begin
            case (seg_q)
                SEG_IDLE: begin
                    seg_d = SEG_IDLE;
                end
                SEG_SYNC: begin
                    increment = 1'b1;
                    bit_start = 1'b1;
                    seg_d     = SEG_TS1;
                    ext_d     = '0;
                    shr_d     = '0;
                    done_d    = 1'b0;
                end
                SEG_TS1: begin
                    if (resync_hit) begin
                        ext_d  = ext_late;
                        done_d = 1'b1;
                    end
`ifdef TRIPLE_SAMPLE_EN
                    smp_pre = ((cnt_w + EW'(2)) == end1_w) || ((cnt_w + EW'(1)) == end1_w);
`endif
                    if (cnt_w == end1_w) begin
                        setctzero = 1'b1;
                        sample_pt = 1'b1;
                        seg_d     = SEG_TS2;
                    end else begin
                        increment = 1'b1;
                    end
                end
                SEG_TS2: begin
                    if (early_as_sync) begin
                        done_d    = 1'b1;
                        setctotwo = 1'b1;
                        seg_d     = SEG_TS1;
                        ext_d     = '0;
                        shr_d     = '0;
                    end else if (resync_hit) begin
                        done_d = 1'b1;
                        shr_d  = sjw;
                        if (cnt_w >= end2_w) begin
                            setctzero = 1'b1;
                            seg_d     = SEG_SYNC;
                        end else begin
                            increment = 1'b1;
                        end
                    end else if (cnt_w == end2_w) begin
                        setctzero = 1'b1;
                        seg_d     = SEG_SYNC;
                    end else begin
                        increment = 1'b1;
                    end
                end
                default: begin
                    seg_d = SEG_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seg_q  <= SEG_IDLE;
            ext_q  <= '0;
            shr_q  <= '0;
            done_q <= 1'b0;
        end else begin
            seg_q  <= seg_d;
            ext_q  <= ext_d;
            shr_q  <= shr_d;
            done_q <= done_d;
        end
    end

    assign seg = seg_q;

endmodule
